voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Polyphonic note-to-voice allocator: accepts note-on/note-off events and assigns each to one of NUM_VOICES envelope voices.
- Drives each voice's gate (`en`) and 32-bit velocity word, and consumes each voice's one-cycle "available" pulse that marks release completion.
- Sits between the MIDI/event front end and the bank of envelope generators; it is the controlling end of the en/available gate protocol.

Parameters:
- NUM_VOICES, 8, number of voices managed (2..16).
- NOTE_BITS, 7, note number width.
- VEL_BITS, 32, velocity word width: [31:16] attack level, [15:0] decay level.
- DROP_BITS, 8, width of the saturating dropped-event counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- evt_valid  in  1  event present.
- evt_ready  out  1  allocator can accept an event this cycle.
- evt_on  in  1  1 = note-on, 0 = note-off.
- evt_note  in  NOTE_BITS  note number.
- evt_velocity  in  VEL_BITS  velocity word (ignored for note-off).
- voice_avail  in  NUM_VOICES  per-voice one-cycle pulse: release finished, voice idle.
- voice_en  out  NUM_VOICES  per-voice gate to the envelope `en` input.
- voice_note  out  NUM_VOICES*NOTE_BITS  per-voice note, voice i at [i*NOTE_BITS +: NOTE_BITS].
- voice_velocity  out  NUM_VOICES*VEL_BITS  per-voice velocity word, same packing.
- voice_busy  out  NUM_VOICES  1 when the voice is not FREE.
- drop_count  out  DROP_BITS  saturating count of note-ons that found no voice.

Behaviour:
- Reset values: all voices FREE, voice_en=0, voice_note=0, voice_velocity=0, voice_busy=0, drop_count=0, evt_ready=0 until the first clock after reset release, control FSM in S_IDLE.
- Per-voice state:
  - FREE: en=0.
  - HELD: en=1.
  - RELEASING: en=0, waiting for avail.
  - voice_busy = (state != FREE).
- Control FSM:
  - S_IDLE: evt_ready=1. On evt_valid&&evt_ready, latch the event and go to S_SCAN with scan index 0.
  - S_SCAN: examine one voice per cycle, index 0..NUM_VOICES-1. Record the first match in each of three classes:
    - same note (HELD or RELEASING);
    - lowest-index FREE voice;
    - lowest-index RELEASING voice.
    After the last index, go to S_COMMIT.
  - S_COMMIT: apply the action, go to S_IDLE. evt_ready is 0 in S_SCAN and S_COMMIT.
- Latency: acceptance to voice_en change is NUM_VOICES+2 cycles. Maximum throughput is one event per NUM_VOICES+2 cycles.
- Note-on commit priority:
  1. Same-note voice: retrigger. Load velocity and set state HELD. If the voice was already HELD, drive en=0 for exactly one cycle (the commit cycle output) and then 1, so the envelope re-enters attack.
  2. Else the FREE voice: load note and velocity, set HELD.
  3. Else the RELEASING voice (steal): load note and velocity, set HELD.
  4. Else drop the event; drop_count increments and saturates at all-ones.
- Note-off commit: the same-note voice, if HELD, goes to RELEASING (en=0). If there is no match, or the match is already RELEASING, nothing changes and drop_count is not affected.
- voice_avail handling:
  - Processed every cycle in every FSM state.
  - A RELEASING voice receiving avail goes to FREE; note and velocity are retained.
  - avail on a FREE or HELD voice is ignored.
- Simultaneous events:
  - If a commit targets a voice in the same cycle that voice gets avail, the commit wins and the voice ends HELD.
  - A voice recorded as RELEASING during scan that becomes FREE before commit is still a valid target.
  - A FREE candidate cannot change before commit, because only the allocator leaves FREE.
- Reset mid-scan or mid-commit: everything returns to reset values immediately (asynchronous) and the latched event is discarded.

Decomposition:
- Shared package synth_pkg holds:
  - voice state encoding: FREE=2'b00, HELD=2'b01, RELEASING=2'b10;
  - FSM state encoding: S_IDLE, S_SCAN, S_COMMIT;
  - default NOTE_BITS and VEL_BITS constants.
- Sub-module voice_slot, instantiated NUM_VOICES times:
  - holds state, note, velocity and the one-cycle retrigger strobe;
  - inputs: commit strobe, release strobe, avail;
  - outputs: en, busy, note, velocity.

Test Plan (NUM_VOICES=4):
- Reset, then note-on note=60 vel=0x8000_4000 → after 6 cycles voice_en=4'b0001, voice_note[0]=60, voice_velocity[0]=0x8000_4000, voice_busy=4'b0001.
- Note-ons 60, 62, 64, 67 → voice_en=4'b1111. A fifth note-on 69 → dropped, drop_count=1, no outputs change. 260 further drops → drop_count saturates at 255.
- With all four held: note-off 62 → voice_en=4'b1101. Note-on 71 → steals voice 1 (note 71, en=1) before any avail pulse.
- Note-on 60 while voice 0 is HELD with note 60 → voice_en[0] low for exactly one cycle, then high; new velocity loaded; no other voice affected.
- Note-off 64, then voice_avail[2] pulse → voice_busy[2]=0. Next note-on 72 → lands in voice 2. Note-off 99 with no match → no change.
- Assert rst low during S_SCAN of an accepted note-on → all outputs zero and the event never appears after rst release. Also cover avail arriving on the same cycle as a commit to that voice → voice ends HELD, en=1.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared encodings for the voice allocator and its voice slots.
package synth_pkg;

    localparam int DEF_NOTE_BITS = 7;
    localparam int DEF_VEL_BITS  = 32;

    typedef enum logic [1:0] {
        FREE      = 2'b00,
        HELD      = 2'b01,
        RELEASING = 2'b10
    } voice_state_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SCAN   = 2'b01,
        S_COMMIT = 2'b10
    } fsm_state_t;

endpackage

// File: rtl/voice_slot.sv
// One envelope voice: state, note, velocity and the retrigger gap strobe.
// A commit on an already-held voice drops the gate for one cycle so the
// envelope sees a fresh rising edge and re-enters attack.
module voice_slot
    import synth_pkg::*;
#(
    parameter int NOTE_BITS = DEF_NOTE_BITS,
    parameter int VEL_BITS  = DEF_VEL_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_commit,
    input  logic                 i_release,
    input  logic                 i_avail,
    input  logic [NOTE_BITS-1:0] i_note,
    input  logic [VEL_BITS-1:0]  i_velocity,
    output logic                 o_en,
    output logic                 o_busy,
    output logic                 o_releasing,
    output logic [NOTE_BITS-1:0] o_note,
    output logic [VEL_BITS-1:0]  o_velocity
);

    voice_state_t         r_state;
    logic                 r_retrig;
    logic [NOTE_BITS-1:0] r_note;
    logic [VEL_BITS-1:0]  r_velocity;

    // Voice state update; a commit outranks an avail pulse in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= FREE;
            r_retrig   <= 1'b0;
            r_note     <= '0;
            r_velocity <= '0;
        end else begin
            r_retrig <= 1'b0;
            if (i_commit) begin
                r_state    <= HELD;
                r_note     <= i_note;
                r_velocity <= i_velocity;
                r_retrig   <= (r_state == HELD);
            end else if (i_release && (r_state == HELD)) begin
                r_state <= RELEASING;
            end else if (i_avail && (r_state == RELEASING)) begin
                r_state <= FREE;
            end
        end
    end

    assign o_en        = (r_state == HELD) && !r_retrig;
    assign o_busy      = (r_state != FREE);
    assign o_releasing = (r_state == RELEASING);
    assign o_note      = r_note;
    assign o_velocity  = r_velocity;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note-to-voice allocator. Each accepted event is scanned against
// every voice, one per cycle, then committed in a single cycle.
//
// state    | meaning
// S_IDLE   | ready for an event; latches it on accept
// S_SCAN   | examines voice r_idx, records same-note / free / releasing hits
// S_COMMIT | retrigger, allocate, steal or drop; release on note-off
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int NOTE_BITS  = DEF_NOTE_BITS,
    parameter int VEL_BITS   = DEF_VEL_BITS,
    parameter int DROP_BITS  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            evt_valid,
    output logic                            evt_ready,
    input  logic                            evt_on,
    input  logic [NOTE_BITS-1:0]            evt_note,
    input  logic [VEL_BITS-1:0]             evt_velocity,
    input  logic [NUM_VOICES-1:0]           voice_avail,
    output logic [NUM_VOICES-1:0]           voice_en,
    output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
    output logic [NUM_VOICES*VEL_BITS-1:0]  voice_velocity,
    output logic [NUM_VOICES-1:0]           voice_busy,
    output logic [DROP_BITS-1:0]            drop_count
);

    localparam int              IDX_W    = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);

    fsm_state_t             r_state;
    fsm_state_t             w_state_nxt;
    logic                   r_alive;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_evt_on;
    logic [NOTE_BITS-1:0]   r_evt_note;
    logic [VEL_BITS-1:0]    r_evt_vel;
    logic                   r_same_found;
    logic [IDX_W-1:0]       r_same_idx;
    logic                   r_free_found;
    logic [IDX_W-1:0]       r_free_idx;
    logic                   r_rel_found;
    logic [IDX_W-1:0]       r_rel_idx;
    logic [DROP_BITS-1:0]   r_drop;

    logic                   w_accept;
    logic [NUM_VOICES-1:0]  w_commit;
    logic [NUM_VOICES-1:0]  w_release;
    logic                   w_drop_inc;
    logic [NUM_VOICES-1:0]  w_releasing;
    logic [NOTE_BITS-1:0]   w_note [NUM_VOICES];
    logic [VEL_BITS-1:0]    w_vel  [NUM_VOICES];

    assign w_accept   = evt_valid && evt_ready;
    assign drop_count = r_drop;

    // State register; r_alive keeps evt_ready low until the first clock out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
        end
    end

    // Next state, handshake and commit strobes.
    always_comb begin
        w_state_nxt = r_state;
        evt_ready   = 1'b0;
        w_commit    = '0;
        w_release   = '0;
        w_drop_inc  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                evt_ready = r_alive;
                if (evt_valid && r_alive) w_state_nxt = S_SCAN;
            end
            S_SCAN: begin
                if (r_idx == IDX_LAST) w_state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                w_state_nxt = S_IDLE;
                if (r_evt_on) begin
                    if (r_same_found)      w_commit[r_same_idx] = 1'b1;
                    else if (r_free_found) w_commit[r_free_idx] = 1'b1;
                    else if (r_rel_found)  w_commit[r_rel_idx]  = 1'b1;
                    else                   w_drop_inc           = 1'b1;
                end else if (r_same_found) begin
                    w_release[r_same_idx] = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Event latch and scan: first hit in each class wins, so indices are lowest-first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx        <= '0;
            r_evt_on     <= 1'b0;
            r_evt_note   <= '0;
            r_evt_vel    <= '0;
            r_same_found <= 1'b0;
            r_same_idx   <= '0;
            r_free_found <= 1'b0;
            r_free_idx   <= '0;
            r_rel_found  <= 1'b0;
            r_rel_idx    <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_idx        <= '0;
                r_evt_on     <= evt_on;
                r_evt_note   <= evt_note;
                r_evt_vel    <= evt_velocity;
                r_same_found <= 1'b0;
                r_free_found <= 1'b0;
                r_rel_found  <= 1'b0;
            end
        end else if (r_state == S_SCAN) begin
            r_idx <= r_idx + 1'b1;
            if (!r_same_found && voice_busy[r_idx] && (w_note[r_idx] == r_evt_note)) begin
                r_same_found <= 1'b1;
                r_same_idx   <= r_idx;
            end
            if (!r_free_found && !voice_busy[r_idx]) begin
                r_free_found <= 1'b1;
                r_free_idx   <= r_idx;
            end
            if (!r_rel_found && w_releasing[r_idx]) begin
                r_rel_found <= 1'b1;
                r_rel_idx   <= r_idx;
            end
        end
    end

    // Saturating count of note-ons that found no voice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop <= '0;
        end else if (w_drop_inc && (r_drop != {DROP_BITS{1'b1}})) begin
            r_drop <= r_drop + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        voice_slot #(
            .NOTE_BITS (NOTE_BITS),
            .VEL_BITS  (VEL_BITS)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .i_commit    (w_commit[g]),
            .i_release   (w_release[g]),
            .i_avail     (voice_avail[g]),
            .i_note      (r_evt_note),
            .i_velocity  (r_evt_vel),
            .o_en        (voice_en[g]),
            .o_busy      (voice_busy[g]),
            .o_releasing (w_releasing[g]),
            .o_note      (w_note[g]),
            .o_velocity  (w_vel[g])
        );
        assign voice_note[g*NOTE_BITS +: NOTE_BITS]  = w_note[g];
        assign voice_velocity[g*VEL_BITS +: VEL_BITS] = w_vel[g];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with four voices.
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int NB = 7;
    localparam int VB = 32;
    localparam int DB = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             evt_valid;
    logic             evt_ready;
    logic             evt_on;
    logic [NB-1:0]    evt_note;
    logic [VB-1:0]    evt_velocity;
    logic [NV-1:0]    voice_avail;
    logic [NV-1:0]    voice_en;
    logic [NV*NB-1:0] voice_note;
    logic [NV*VB-1:0] voice_velocity;
    logic [NV-1:0]    voice_busy;
    logic [DB-1:0]    drop_count;

    int checks = 0;
    int errors = 0;

    voice_allocator #(
        .NUM_VOICES (NV),
        .NOTE_BITS  (NB),
        .VEL_BITS   (VB),
        .DROP_BITS  (DB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_on         (evt_on),
        .evt_note       (evt_note),
        .evt_velocity   (evt_velocity),
        .voice_avail    (voice_avail),
        .voice_en       (voice_en),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_busy     (voice_busy),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present one event at a negedge and hold it through the accepting edge.
    task automatic issue(input logic on, input logic [NB-1:0] n, input logic [VB-1:0] v);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!evt_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check_eq("ready_timeout", 32'(evt_ready), 32'd1);
        evt_valid    = 1'b1;
        evt_on       = on;
        evt_note     = n;
        evt_velocity = v;
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
    endtask

    // Issue and wait through scan and commit (accept edge + 5 more edges).
    task automatic run_evt(input logic on, input logic [NB-1:0] n, input logic [VB-1:0] v);
        issue(on, n, v);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic pulse_avail(input logic [NV-1:0] mask);
        @(negedge clk);
        voice_avail = mask;
        @(posedge clk);
        #1;
        voice_avail = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        evt_valid    = 1'b0;
        evt_on       = 1'b0;
        evt_note     = '0;
        evt_velocity = '0;
        voice_avail  = '0;
        #1;
        check_eq("rst_en", 32'(voice_en), 32'h0);
        check_eq("rst_busy", 32'(voice_busy), 32'h0);
        check_eq("rst_drop", 32'(drop_count), 32'h0);
        check_eq("rst_ready", 32'(evt_ready), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("ready_before_clk", 32'(evt_ready), 32'h0);
        @(posedge clk);
        #1;
        check_eq("ready_after_clk", 32'(evt_ready), 32'h1);

        // First note-on: gate rises on the sixth edge after the event is driven.
        issue(1'b1, 7'd60, 32'h8000_4000);
        repeat (4) @(posedge clk);
        #1;
        check_eq("lat_before", 32'(voice_en), 32'h0);
        check_eq("ready_busy", 32'(evt_ready), 32'h0);
        @(posedge clk);
        #1;
        check_eq("lat_en", 32'(voice_en), 32'h1);
        check_eq("v0_note", 32'(voice_note[0 +: NB]), 32'd60);
        check_eq("v0_vel", voice_velocity[0 +: VB], 32'h8000_4000);
        check_eq("busy_1", 32'(voice_busy), 32'h1);

        run_evt(1'b1, 7'd62, 32'h1111_2222);
        run_evt(1'b1, 7'd64, 32'h3333_4444);
        run_evt(1'b1, 7'd67, 32'h5555_6666);
        check_eq("all_held", 32'(voice_en), 32'hF);
        check_eq("v1_note", 32'(voice_note[NB +: NB]), 32'd62);
        check_eq("v3_note", 32'(voice_note[3*NB +: NB]), 32'd67);
        check_eq("v2_vel", voice_velocity[2*VB +: VB], 32'h3333_4444);

        run_evt(1'b1, 7'd69, 32'hDEAD_BEEF);
        check_eq("drop_1", 32'(drop_count), 32'd1);
        check_eq("drop_en", 32'(voice_en), 32'hF);
        check_eq("drop_notes", 32'(voice_note), {4'h0, 7'd67, 7'd64, 7'd62, 7'd60});
        for (int i = 0; i < 260; i++) run_evt(1'b1, 7'd69, 32'h0);
        check_eq("drop_sat", 32'(drop_count), 32'd255);

        // Release then steal voice 1 before any avail.
        run_evt(1'b0, 7'd62, 32'h0);
        check_eq("off62_en", 32'(voice_en), 32'hD);
        check_eq("off62_busy", 32'(voice_busy), 32'hF);
        run_evt(1'b1, 7'd71, 32'h7777_0001);
        check_eq("steal_en", 32'(voice_en), 32'hF);
        check_eq("steal_note", 32'(voice_note[NB +: NB]), 32'd71);

        // Retrigger voice 0: one-cycle gate gap, new velocity.
        issue(1'b1, 7'd60, 32'h1234_5678);
        repeat (4) @(posedge clk);
        #1;
        check_eq("retrig_pre", 32'(voice_en), 32'hF);
        @(posedge clk);
        #1;
        check_eq("retrig_gap", 32'(voice_en), 32'hE);
        check_eq("retrig_vel", voice_velocity[0 +: VB], 32'h1234_5678);
        @(posedge clk);
        #1;
        check_eq("retrig_back", 32'(voice_en), 32'hF);
        check_eq("retrig_notes", 32'(voice_note), {4'h0, 7'd67, 7'd64, 7'd71, 7'd60});

        // Release, avail frees the voice, next note reuses it.
        run_evt(1'b0, 7'd64, 32'h0);
        check_eq("off64_en", 32'(voice_en), 32'hB);
        pulse_avail(4'b0100);
        check_eq("avail_busy", 32'(voice_busy), 32'hB);
        check_eq("avail_keep_note", 32'(voice_note[2*NB +: NB]), 32'd64);
        run_evt(1'b1, 7'd72, 32'h0000_0072);
        check_eq("reuse_en", 32'(voice_en), 32'hF);
        check_eq("reuse_note", 32'(voice_note[2*NB +: NB]), 32'd72);
        run_evt(1'b0, 7'd99, 32'h0);
        check_eq("off99_en", 32'(voice_en), 32'hF);
        check_eq("off99_drop", 32'(drop_count), 32'd255);
        pulse_avail(4'b0001);
        check_eq("avail_held_ign", 32'(voice_busy), 32'hF);

        // Avail lands in the commit cycle of a retrigger on a releasing voice.
        run_evt(1'b0, 7'd67, 32'h0);
        check_eq("off67_en", 32'(voice_en), 32'h7);
        issue(1'b1, 7'd67, 32'hAAAA_5555);
        repeat (4) @(posedge clk);
        @(negedge clk);
        voice_avail = 4'b1000;
        @(posedge clk);
        #1;
        voice_avail = '0;
        check_eq("race_en", 32'(voice_en), 32'hF);
        check_eq("race_vel", voice_velocity[3*VB +: VB], 32'hAAAA_5555);

        // Voice scanned as releasing goes free before commit; still stolen.
        run_evt(1'b0, 7'd67, 32'h0);
        issue(1'b1, 7'd80, 32'h0000_0080);
        repeat (3) @(posedge clk);
        @(negedge clk);
        voice_avail = 4'b1000;
        @(posedge clk);
        #1;
        voice_avail = '0;
        @(posedge clk);
        #1;
        check_eq("late_free_en", 32'(voice_en), 32'hF);
        check_eq("late_free_note", 32'(voice_note[3*NB +: NB]), 32'd80);

        // Reset during scan discards the latched event.
        issue(1'b1, 7'd90, 32'h0000_0090);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_en", 32'(voice_en), 32'h0);
        check_eq("mid_rst_busy", 32'(voice_busy), 32'h0);
        check_eq("mid_rst_note", 32'(voice_note), 32'h0);
        check_eq("mid_rst_drop", 32'(drop_count), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("post_rst_en", 32'(voice_en), 32'h0);
        check_eq("post_rst_busy", 32'(voice_busy), 32'h0);
        run_evt(1'b1, 7'd61, 32'h0001_0002);
        check_eq("post_rst_alloc", 32'(voice_en), 32'h1);
        check_eq("post_rst_note", 32'(voice_note[0 +: NB]), 32'd61);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
